// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that can hold 0..bin_w.
  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

  // 10**n, used to confirm at elaboration that DIGITS covers the input range.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request / result handshake bundle of the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 9,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      binary;
  logic                  signed_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign;
  logic                  busy;

  modport master (
    output in_valid, binary, signed_mode, out_ready,
    input  in_ready, out_valid, bcd, sign, busy
  );

  modport slave (
    input  in_valid, binary, signed_mode, out_ready,
    output in_ready, out_valid, bcd, sign, busy
  );
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// Single-digit double-dabble correction: add 3 when the digit is 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Correction so the following left shift carries into the next digit at 10.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock,
// optional two's-complement input with a separate sign output.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 9,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int              CNT_W   = cnt_w(BIN_W);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(BIN_W - 1);
  localparam longint unsigned MAX_BIN = (64'd1 << BIN_W) - 64'd1;

  if (pow10(DIGITS) <= MAX_BIN) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [BIN_W-1:0]      mag;
  logic [BIN_W-1:0]      shreg;
  logic [4*DIGITS-1:0]   acc;
  logic [4*DIGITS-1:0]   adj;
  logic                  neg;
  logic                  sign_r;
  logic                  accept;
  logic                  last_step;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_step = (cnt == LAST);

  // Magnitude of the request; the most negative value wraps onto its own bit pattern,
  // which read as unsigned is exactly 2**(BIN_W-1).
  always_comb begin
    neg = bus.signed_mode & bus.binary[BIN_W-1];
    mag = bus.binary;
    if (neg) begin
      mag = ~bus.binary + BIN_W'(1);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = CONV;
      CONV:    if (last_step)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Step counter: cleared on accept, advanced once per conversion step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == CONV) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Datapath: load on accept, then correct-and-shift {acc, shreg} each CONV cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg  <= mag;
      acc    <= '0;
      sign_r <= neg & (mag != '0);
    end else if (state == CONV) begin
      acc   <= {adj[4*DIGITS-2:0], shreg[BIN_W-1]};
      shreg <= {shreg[BIN_W-2:0], 1'b0};
    end
  end

  // Outputs decoded from state; result is masked to zero outside DONE.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state == CONV);
    bus.out_valid = (state == DONE);
    bus.bcd       = '0;
    bus.sign      = 1'b0;
    if (state == DONE) begin
      bus.bcd  = acc;
      bus.sign = sign_r;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised and directed bench for bin_to_bcd_seq with an arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  bin_to_bcd_seq_if #(.BIN_W(9),  .DIGITS(3)) bus9  ();
  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) bus16 ();

  bin_to_bcd_seq #(.BIN_W(9), .DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus9.slave)
  );

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal digits of v packed as BCD, digit 0 lowest.
  function automatic logic [63:0] to_bcd(input longint unsigned v, input int d);
    logic [63:0]     r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r = r | (64'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  // One full transaction on the 9-bit instance. hold = cycles OUT_READY stays low
  // in DONE (ignored when rnd_ready, where OUT_READY is random each cycle).
  task automatic conv9(input logic [8:0] b, input logic sm, input int hold, input bit rnd_ready);
    longint unsigned v;
    logic [63:0]     eb;
    logic            es;
    int              t;
    bit              r;
    bit              done;
    v  = longint'(b);
    es = 1'b0;
    if (sm && b[8]) begin
      v  = 512 - v;
      es = (v != 0);
    end
    eb = to_bcd(v, 3);

    t = 0;
    while (!bus9.in_ready && t < 20) begin
      tick();
      t++;
    end
    check("wait_in_ready", 64'(bus9.in_ready), 64'd1);

    bus9.in_valid    = 1'b1;
    bus9.binary      = b;
    bus9.signed_mode = sm;
    tick();
    bus9.in_valid    = 1'b0;
    bus9.binary      = 9'($urandom);
    bus9.signed_mode = 1'($urandom);
    check("busy_after_accept", 64'(bus9.busy), 64'd1);
    check("in_ready_conv", 64'(bus9.in_ready), 64'd0);

    for (int i = 1; i <= 9; i++) begin
      if (i == 3) bus9.in_valid = 1'b1;
      if (i == 5) bus9.in_valid = 1'b0;
      tick();
      if (i == 8) begin
        check("out_valid_early", 64'(bus9.out_valid), 64'd0);
        check("bcd_zero_conv", 64'(bus9.bcd), 64'd0);
      end
    end
    check("out_valid_A9", 64'(bus9.out_valid), 64'd1);
    check("bcd", 64'(bus9.bcd), eb);
    check("sign", 64'(bus9.sign), 64'(es));
    check("busy_done", 64'(bus9.busy), 64'd0);
    check("in_ready_done", 64'(bus9.in_ready), 64'd0);

    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      r = rnd_ready ? 1'($urandom_range(0, 1)) : (k >= hold);
      if (k == 63) r = 1'b1;
      bus9.out_ready = r;
      bus9.in_valid  = r;
      tick();
      if (r) begin
        done = 1'b1;
      end else begin
        check("hold_bcd", 64'(bus9.bcd), eb);
        check("hold_valid", 64'(bus9.out_valid), 64'd1);
        check("hold_in_ready", 64'(bus9.in_ready), 64'd0);
      end
    end
    bus9.out_ready = 1'b0;
    bus9.in_valid  = 1'b0;
    check("idle_after_hs", 64'(bus9.in_ready), 64'd1);
    check("no_accept_on_hs", 64'(bus9.busy), 64'd0);
    check("valid_after_hs", 64'(bus9.out_valid), 64'd0);
    check("bcd_idle", 64'(bus9.bcd), 64'd0);
  endtask

  initial begin
    logic [8:0] rb;
    logic       rs;
    int         pick;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus9.in_valid = 1'b0;  bus9.binary = '0;  bus9.signed_mode = 1'b0;  bus9.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.binary = '0; bus16.signed_mode = 1'b0; bus16.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 64'(bus9.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus9.out_valid), 64'd0);
    check("rst_busy", 64'(bus9.busy), 64'd0);
    check("rst_bcd", 64'(bus9.bcd), 64'd0);
    check("rst_sign", 64'(bus9.sign), 64'd0);
    rst_n = 1'b1;

    // Directed corner values.
    conv9(9'd0,   1'b0, 0, 1'b0);
    conv9(9'd511, 1'b0, 5, 1'b0);
    conv9(9'h100, 1'b1, 1, 1'b0);
    conv9(9'h1FF, 1'b1, 0, 1'b0);
    conv9(9'h0FF, 1'b1, 2, 1'b0);

    // Wide instance: full-scale value, IN_VALID pulsed mid-conversion.
    bus16.in_valid = 1'b1;
    bus16.binary   = 16'hFFFF;
    tick();
    bus16.in_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) bus16.in_valid = 1'b1;
      if (i == 6) bus16.in_valid = 1'b0;
      tick();
      if (i == 6) check("w16_busy_ignored", 64'(bus16.busy), 64'd1);
      if (i == 15) check("w16_valid_early", 64'(bus16.out_valid), 64'd0);
    end
    check("w16_valid", 64'(bus16.out_valid), 64'd1);
    check("w16_bcd", 64'(bus16.bcd), 64'h65535);
    check("w16_sign", 64'(bus16.sign), 64'd0);
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    check("w16_idle", 64'(bus16.in_ready), 64'd1);

    // Reset in the middle of a conversion.
    bus9.in_valid = 1'b1;
    bus9.binary   = 9'd300;
    tick();
    bus9.in_valid = 1'b0;
    repeat (4) tick();
    check("pre_rst_busy", 64'(bus9.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus9.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus9.in_ready), 64'd1);
    check("mid_rst_busy", 64'(bus9.busy), 64'd0);
    check("mid_rst_bcd", 64'(bus9.bcd), 64'd0);
    #1;
    rst_n = 1'b1;
    conv9(9'd123, 1'b0, 0, 1'b0);

    // Random transactions, both modes, with extremes mixed in.
    for (int n = 0; n < 1000; n++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0:       rb = 9'h000;
        1:       rb = 9'h1FF;
        2:       rb = 9'h100;
        3:       rb = 9'h0FF;
        default: rb = 9'($urandom);
      endcase
      rs = 1'($urandom);
      conv9(rb, rs, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter BIN_W, default 9, binary input width (2..32).
REQ-002 Parameter DIGITS, default 3, BCD output digit count; 10**DIGITS > 2**BIN_W-1 SHALL hold, else elaboration error.
REQ-003 CLK  input  1  clock; all state SHALL change on the rising edge only.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 IN_VALID  input  1  request carrying BINARY and SIGNED_MODE.
REQ-006 IN_READY  output  1  block can accept a request.
REQ-007 BINARY  input  BIN_W  value to convert.
REQ-008 SIGNED_MODE  input  1  1 = BINARY is two's complement.
REQ-009 OUT_VALID  output  1  BCD/SIGN hold a valid result.
REQ-010 OUT_READY  input  1  consumer accepts the result.
REQ-011 BCD  output  4*DIGITS  result, digit 0 in bits [3:0], most significant digit at the top.
REQ-012 SIGN  output  1  1 = result negative (signed mode only).
REQ-013 BUSY  output  1  conversion in progress.

Function
REQ-014 The block SHALL be an FSM with states IDLE, CONV and DONE.
REQ-015 IDLE: IN_READY=1; IN_VALID=1 at an edge SHALL accept the request and enter CONV.
- Latch magnitude into shift register, SIGNED_MODE into the sign path, clear the BCD accumulator and the bit counter.
REQ-016 Magnitude SHALL be BINARY if SIGNED_MODE=0 or BINARY[BIN_W-1]=0, else the BIN_W-bit two's-complement negation (-2**(BIN_W-1) maps to 2**(BIN_W-1)).
REQ-017 SIGN SHALL be 1 only if SIGNED_MODE=1, BINARY[BIN_W-1]=1 and the magnitude is nonzero.
REQ-018 CONV: each edge SHALL perform one double-dabble step.
- Every BCD digit >= 5 gets +3.
- Then {accumulator, shift register} shifts left 1, MSB of the magnitude first.
REQ-019 After exactly BIN_W CONV steps the block SHALL enter DONE; OUT_VALID SHALL rise at edge A+BIN_W, where A is the accept edge.
REQ-020 DONE: OUT_VALID=1; BCD and SIGN SHALL stay stable until the edge where OUT_READY=1, which returns the block to IDLE.
REQ-021 IN_READY SHALL be 0 in CONV and DONE; IN_VALID there SHALL be ignored, with no queuing.
REQ-022 A new request SHALL NOT be accepted in the same cycle as the result handshake; the earliest next accept is the following edge.
REQ-023 BUSY SHALL equal (state==CONV).
REQ-024 BCD digits SHALL always be 0..9 when OUT_VALID=1; BCD SHALL read 0 outside DONE.

Reset
REQ-025 RST_N=0 SHALL immediately force the following, regardless of state, including mid-CONV:
- IDLE state.
- OUT_VALID=0, BCD=0, SIGN=0, BUSY=0, counter=0.
- IN_READY=1.
REQ-026 After RST_N deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-027 Package bcd_pkg SHALL hold the state enum (IDLE, CONV, DONE) and the counter-width function clog2(BIN_W+1).
REQ-028 Sub-module bcd_add3 (4-bit in, 4-bit out: +3 if >=5) SHALL be instantiated DIGITS times via generate.
REQ-029 No other sub-modules; target 120-400 lines of RTL total.

Verification
REQ-030 Defaults, BINARY=0, SIGNED_MODE=0 -> after 9 cycles OUT_VALID=1, BCD=12'h000, SIGN=0.
REQ-031 Defaults, BINARY=511, unsigned -> BCD=12'h511 at A+9; OUT_READY held 0 for 5 cycles -> BCD and OUT_VALID stable, IN_READY=0.
REQ-032 Defaults, BINARY=9'h100, SIGNED_MODE=1 -> BCD=12'h256, SIGN=1; BINARY=9'h1FF signed -> BCD=12'h001, SIGN=1.
REQ-033 BIN_W=16, DIGITS=5, BINARY=65535 unsigned -> BCD=20'h65535 at A+16; IN_VALID pulsed during CONV -> ignored.
REQ-034 Reset mid-CONV (cycle 4 of 9) -> OUT_VALID=0, IN_READY=1 at once; then BINARY=123 -> BCD=12'h123.
REQ-035 Random 1000 inputs, both modes, random OUT_READY -> BCD decodes to |value| and SIGN is correct in every case.
